// File: rtl/arcade_game_control.sv
// ---------------------------------------------------------------------------
// arcade_game_control
//   Coin / credit / game-timer controller for the arcade cores.
//   Raw coin and start switches are synchronised and debounced, coins add
//   credits (saturating at CREDIT_MAX), and a start consumes one credit and
//   launches a frame-counted game followed by a fixed post-game hold.
//
// Ports
//   CLOCK            in   core clock, all state on the rising edge
//   RESET_N          in   asynchronous active-low reset
//   COINAGE          in   0: 1 credit per coin, 1: ALT_COIN_CREDITS per coin
//   PLAYTIME[3:0]    in   game length step 0..10 (larger values clamp to 10)
//   COIN_SW          in   raw coin switch, active high, asynchronous
//   START_GAME       in   raw start button, active high, asynchronous
//   FRAME_TICK       in   one-cycle pulse per video frame
//   GAME_ON          out  high while PLAYING
//   ATTRACT          out  high while in ATTRACT
//   CREDITS[CW-1:0]  out  current credit count
//   TIME_LEFT[TW-1:0] out frames remaining in the game, 0 outside PLAYING
//   CREDIT_LIGHT_N   out  low when credits are available and not PLAYING
//   GAME_START_PULSE out  one cycle on ATTRACT->PLAYING
//   GAME_END_PULSE   out  one cycle on PLAYING->GAME_OVER
// ---------------------------------------------------------------------------

// Two-flop synchroniser, level debouncer and rising-edge detector.
module arcade_game_control_debounce #(
    parameter int LEN = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o
);
    localparam int DW = $clog2(LEN + 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Count consecutive cycles where the synchronised input disagrees with
    // the accepted level; flip the accepted level once LEN cycles are seen.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q != level_q) begin
            if (cnt_q == DW'(LEN - 1)) begin
                level_d = sync_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser, debounce counter and edge-detect history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            meta_q       <= raw_i;
            sync_q       <= meta_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign rise_o = level_q & ~level_prev_q;
endmodule

module arcade_game_control #(
    parameter int  CREDIT_MAX       = 9,
    parameter int  ALT_COIN_CREDITS = 2,
    parameter int  DEBOUNCE_LEN     = 1024,
    parameter int  BASE_FRAMES      = 3600,
    parameter int  STEP_FRAMES      = 360,
    parameter int  HOLD_FRAMES      = 120,
    localparam int CW               = $clog2(CREDIT_MAX + 1),
    localparam int TW               = $clog2(BASE_FRAMES + 10 * STEP_FRAMES + 1)
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          COINAGE,
    input  logic [3:0]    PLAYTIME,
    input  logic          COIN_SW,
    input  logic          START_GAME,
    input  logic          FRAME_TICK,
    output logic          GAME_ON,
    output logic          ATTRACT,
    output logic [CW-1:0] CREDITS,
    output logic [TW-1:0] TIME_LEFT,
    output logic          CREDIT_LIGHT_N,
    output logic          GAME_START_PULSE,
    output logic          GAME_END_PULSE
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    // Credit arithmetic is done two bits wider so add-then-subtract cannot wrap.
    localparam int AW = CW + 2;

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] time_q;
    logic [TW-1:0] time_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_d;

    logic          game_on_q;
    logic          game_on_d;
    logic          attract_q;
    logic          attract_d;
    logic          light_n_q;
    logic          light_n_d;
    logic          start_pulse_q;
    logic          start_pulse_d;
    logic          end_pulse_q;
    logic          end_pulse_d;

    logic          coin_ev_s;
    logic          start_ev_s;
    logic          start_ok_s;
    logic          end_s;
    logic [3:0]    pt_clamp_s;
    logic [TW-1:0] game_len_s;
    logic [AW-1:0] add_s;
    logic [AW-1:0] credit_sum_s;

    arcade_game_control_debounce #(.LEN(DEBOUNCE_LEN)) u_coin_db (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .raw_i  (COIN_SW),
        .rise_o (coin_ev_s)
    );

    arcade_game_control_debounce #(.LEN(DEBOUNCE_LEN)) u_start_db (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .raw_i  (START_GAME),
        .rise_o (start_ev_s)
    );

    assign pt_clamp_s = (PLAYTIME > 4'd10) ? 4'd10 : PLAYTIME;
    assign game_len_s = TW'(BASE_FRAMES) + TW'(STEP_FRAMES) * TW'(pt_clamp_s);

    // Next-state logic: game state, frame timer and post-game hold counter.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        hold_d     = hold_q;
        start_ok_s = 1'b0;
        end_s      = 1'b0;
        case (state_q)
            ST_ATTRACT: begin
                if (start_ev_s && (credits_q != '0)) begin
                    state_d    = ST_PLAYING;
                    time_d     = game_len_s;
                    start_ok_s = 1'b1;
                end else begin
                    state_d = ST_ATTRACT;
                end
            end
            ST_PLAYING: begin
                if (FRAME_TICK) begin
                    if (time_q > TW'(1)) begin
                        time_d = time_q - TW'(1);
                    end else begin
                        time_d  = '0;
                        state_d = ST_GAME_OVER;
                        hold_d  = HW'(HOLD_FRAMES);
                        end_s   = 1'b1;
                    end
                end else begin
                    time_d = time_q;
                end
            end
            ST_GAME_OVER: begin
                if (FRAME_TICK) begin
                    if (hold_q > HW'(1)) begin
                        hold_d = hold_q - HW'(1);
                    end else begin
                        hold_d  = '0;
                        state_d = ST_ATTRACT;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
                time_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Credit update: coins count in every state, an accepted start takes one.
    always_comb begin
        if (coin_ev_s) begin
            add_s = COINAGE ? AW'(ALT_COIN_CREDITS) : AW'(1);
        end else begin
            add_s = '0;
        end
        credit_sum_s = {2'b00, credits_q} + add_s - (start_ok_s ? AW'(1) : AW'(0));
        if (credit_sum_s > AW'(CREDIT_MAX)) begin
            credits_d = CW'(CREDIT_MAX);
        end else begin
            credits_d = credit_sum_s[CW-1:0];
        end
    end

    // Output decode from next-state values so registered outputs line up
    // with the state and credit registers.
    always_comb begin
        game_on_d     = (state_d == ST_PLAYING);
        attract_d     = (state_d == ST_ATTRACT);
        light_n_d     = !((credits_d != '0) && (state_d != ST_PLAYING));
        start_pulse_d = start_ok_s;
        end_pulse_d   = end_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_ATTRACT;
            time_q        <= '0;
            hold_q        <= '0;
            credits_q     <= '0;
            game_on_q     <= 1'b0;
            attract_q     <= 1'b1;
            light_n_q     <= 1'b1;
            start_pulse_q <= 1'b0;
            end_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            hold_q        <= hold_d;
            credits_q     <= credits_d;
            game_on_q     <= game_on_d;
            attract_q     <= attract_d;
            light_n_q     <= light_n_d;
            start_pulse_q <= start_pulse_d;
            end_pulse_q   <= end_pulse_d;
        end
    end

    assign GAME_ON          = game_on_q;
    assign ATTRACT          = attract_q;
    assign CREDITS          = credits_q;
    assign TIME_LEFT        = time_q;
    assign CREDIT_LIGHT_N   = light_n_q;
    assign GAME_START_PULSE = start_pulse_q;
    assign GAME_END_PULSE   = end_pulse_q;
endmodule

// File: tb/tb_arcade_game_control.sv
// ---------------------------------------------------------------------------
// tb_arcade_game_control
//   Directed stimulus with hand-computed expected output events. Stimulus
//   pushes each expected event into a queue; a monitor pops and compares
//   whenever CREDITS/GAME_ON/ATTRACT change or a pulse fires.
// ---------------------------------------------------------------------------
module tb_arcade_game_control;
    localparam int DL = 8;
    localparam int CW = 4;
    localparam int TW = 13;

    logic          CLOCK;
    logic          RESET_N;
    logic          COINAGE;
    logic [3:0]    PLAYTIME;
    logic          COIN_SW;
    logic          START_GAME;
    logic          FRAME_TICK;
    logic          GAME_ON;
    logic          ATTRACT;
    logic [CW-1:0] CREDITS;
    logic [TW-1:0] TIME_LEFT;
    logic          CREDIT_LIGHT_N;
    logic          GAME_START_PULSE;
    logic          GAME_END_PULSE;

    arcade_game_control #(
        .CREDIT_MAX       (9),
        .ALT_COIN_CREDITS (2),
        .DEBOUNCE_LEN     (DL),
        .BASE_FRAMES      (3600),
        .STEP_FRAMES      (360),
        .HOLD_FRAMES      (120)
    ) dut (
        .CLOCK            (CLOCK),
        .RESET_N          (RESET_N),
        .COINAGE          (COINAGE),
        .PLAYTIME         (PLAYTIME),
        .COIN_SW          (COIN_SW),
        .START_GAME       (START_GAME),
        .FRAME_TICK       (FRAME_TICK),
        .GAME_ON          (GAME_ON),
        .ATTRACT          (ATTRACT),
        .CREDITS          (CREDITS),
        .TIME_LEFT        (TIME_LEFT),
        .CREDIT_LIGHT_N   (CREDIT_LIGHT_N),
        .GAME_START_PULSE (GAME_START_PULSE),
        .GAME_END_PULSE   (GAME_END_PULSE)
    );

    typedef struct {
        int   id;
        int   cred;
        logic on;
        logic att;
        logic ln;
        logic sp;
        logic ep;
        int   tl;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    function automatic exp_t mk(input int id, input int cred, input logic on, input logic att,
                                input logic ln, input logic sp, input logic ep, input int tl);
        exp_t e;
        e.id = id; e.cred = cred; e.on = on; e.att = att; e.ln = ln;
        e.sp = sp; e.ep = ep; e.tl = tl; e.cyc = -1;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one comparison per observed output event.
    initial begin : monitor
        int   p_cred;
        logic p_on, p_att;
        exp_t e;
        p_cred = 0; p_on = 1'b0; p_att = 1'b1;
        forever begin
            @(negedge CLOCK);
            if (RESET_N && ((int'(CREDITS) != p_cred) || (GAME_ON != p_on) || (ATTRACT != p_att)
                            || GAME_START_PULSE || GAME_END_PULSE)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d: got cred=%0d on=%0b att=%0b sp=%0b ep=%0b expected no event",
                             cyc, CREDITS, GAME_ON, ATTRACT, GAME_START_PULSE, GAME_END_PULSE);
                end else begin
                    e = q.pop_front();
                    if ((int'(CREDITS) != e.cred) || (GAME_ON != e.on) || (ATTRACT != e.att) ||
                        (CREDIT_LIGHT_N != e.ln) || (GAME_START_PULSE != e.sp) ||
                        (GAME_END_PULSE != e.ep) || (int'(TIME_LEFT) != e.tl)) begin
                        errors++;
                        $display("FAIL event%0d: got cred=%0d on=%0b att=%0b ln=%0b sp=%0b ep=%0b tl=%0d expected cred=%0d on=%0b att=%0b ln=%0b sp=%0b ep=%0b tl=%0d",
                                 e.id, CREDITS, GAME_ON, ATTRACT, CREDIT_LIGHT_N, GAME_START_PULSE,
                                 GAME_END_PULSE, TIME_LEFT, e.cred, e.on, e.att, e.ln, e.sp, e.ep, e.tl);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL event%0d_latency: got cycle %0d expected cycle %0d", e.id, cyc, e.cyc);
                        end
                    end
                end
            end
            p_cred = int'(CREDITS);
            p_on   = GAME_ON;
            p_att  = ATTRACT;
        end
    end

    // Hold the selected switches for len cycles; optionally assert FRAME_TICK
    // exactly on the cycle the debounced event is applied.
    task automatic press(input logic do_coin, input logic do_start, input logic do_tick,
                         input int len, input logic has_ev, input exp_t e);
        int   c;
        exp_t ee;
        @(negedge CLOCK);
        c = cyc;
        if (has_ev) begin
            ee     = e;
            ee.cyc = c + DL + 3;
            q.push_back(ee);
        end
        COIN_SW    = do_coin;
        START_GAME = do_start;
        for (int i = 1; i <= len; i++) begin
            @(negedge CLOCK);
            if (do_tick) FRAME_TICK = (i == DL + 2);
        end
        COIN_SW    = 1'b0;
        START_GAME = 1'b0;
        FRAME_TICK = 1'b0;
        repeat (DL + 6) @(negedge CLOCK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            FRAME_TICK = 1'b1;
            @(negedge CLOCK);
            FRAME_TICK = 1'b0;
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK);
        chk("rst_credits", int'(CREDITS), 0);
        chk("rst_game_on", int'(GAME_ON), 0);
        chk("rst_attract", int'(ATTRACT), 1);
        chk("rst_time_left", int'(TIME_LEFT), 0);
        chk("rst_light_n", int'(CREDIT_LIGHT_N), 1);
        chk("rst_pulses", int'({GAME_START_PULSE, GAME_END_PULSE}), 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);
    endtask

    exp_t none;

    initial begin
        none       = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        RESET_N    = 1'b0;
        COINAGE    = 1'b0;
        PLAYTIME   = 4'd0;
        COIN_SW    = 1'b0;
        START_GAME = 1'b0;
        FRAME_TICK = 1'b0;
        do_reset();

        // Three single-credit coins, each timed from its rising edge.
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(3, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        chk("three_coins_credits", int'(CREDITS), 3);
        chk("three_coins_light_n", int'(CREDIT_LIGHT_N), 0);

        // Glitch one cycle short of the debounce length is rejected.
        press(1'b1, 1'b0, 1'b0, DL - 1, 1'b0, none);
        chk("glitch_credits", int'(CREDITS), 3);

        // Two credits per coin, saturating at 9.
        COINAGE = 1'b1;
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(4, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(5, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(6, 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0, DL + 5, 1'b0, none);
        chk("saturated_credits", int'(CREDITS), 9);

        do_reset();
        // Start with no credits is ignored.
        press(1'b0, 1'b1, 1'b0, DL + 5, 1'b0, none);
        chk("start_nocred_attract", int'(ATTRACT), 1);
        chk("start_nocred_credits", int'(CREDITS), 0);

        COINAGE = 1'b0;
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(7, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        PLAYTIME = 4'd2;
        press(1'b0, 1'b1, 1'b0, DL + 5, 1'b1, mk(8, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4320));
        chk("pt2_time_left", int'(TIME_LEFT), 4320);
        chk("start_pulse_done", int'(GAME_START_PULSE), 0);

        // Start while playing is ignored; PLAYTIME changes do not matter now.
        PLAYTIME = 4'd15;
        press(1'b0, 1'b1, 1'b0, DL + 5, 1'b0, none);
        chk("start_playing_credits", int'(CREDITS), 0);
        chk("start_playing_game_on", int'(GAME_ON), 1);
        chk("start_playing_time", int'(TIME_LEFT), 4320);

        ticks(4319);
        chk("pt2_time_one", int'(TIME_LEFT), 1);
        q.push_back(mk(9, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
        ticks(1);
        chk("pt2_end_time", int'(TIME_LEFT), 0);

        // Coin counts during GAME_OVER; start there is ignored.
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(10, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        press(1'b0, 1'b1, 1'b0, DL + 5, 1'b0, none);
        chk("start_over_credits", int'(CREDITS), 1);
        chk("start_over_attract", int'(ATTRACT), 0);
        chk("start_over_game_on", int'(GAME_ON), 0);
        ticks(119);
        chk("hold_119_attract", int'(ATTRACT), 0);
        q.push_back(mk(11, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        ticks(1);

        // PLAYTIME=15 clamps to 7200 frames; tick on the start cycle is not counted.
        press(1'b0, 1'b1, 1'b1, DL + 5, 1'b1, mk(12, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7200));
        chk("pt15_time_left", int'(TIME_LEFT), 7200);
        ticks(7199);
        chk("pt15_time_one", int'(TIME_LEFT), 1);
        chk("pt15_game_on", int'(GAME_ON), 1);
        q.push_back(mk(13, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
        ticks(1);
        chk("pt15_end_time", int'(TIME_LEFT), 0);
        ticks(119);
        chk("pt15_hold_119", int'(ATTRACT), 0);
        q.push_back(mk(14, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        ticks(1);

        // Coin and start accepted together: 1 + 2 - 1 = 2.
        COINAGE = 1'b0;
        press(1'b1, 1'b0, 1'b0, DL + 5, 1'b1, mk(15, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        COINAGE  = 1'b1;
        PLAYTIME = 4'd0;
        press(1'b1, 1'b1, 1'b0, DL + 5, 1'b1, mk(16, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3600));
        ticks(5);
        chk("dual_time_left", int'(TIME_LEFT), 3595);

        // Asynchronous reset mid-game, checked before the next clock edge.
        @(negedge CLOCK);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_credits", int'(CREDITS), 0);
        chk("async_rst_attract", int'(ATTRACT), 1);
        chk("async_rst_time", int'(TIME_LEFT), 0);
        chk("async_rst_game_on", int'(GAME_ON), 0);
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLOCK);
        chk("post_rst_credits", int'(CREDITS), 0);
        chk("pending_events", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
